xctrl_v2: RTL and testbench

Parametrised next-generation accumulator controller for the datapath fabric. It fetches from an asynchronous-read program ROM and executes one instruction per cycle, except external data-bus accesses, which stall on a `data_ready` handshake with a bounded timeout. It adds a hardware call/return stack and sticky error flags. It occupies the same position as the current controller: program ROM on one side, data/register-file bus on the other.

---
 rtl/xctrl_v2.sv | 207 ++++++++++++++++++++
 tb/tb_xctrl_v2.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xctrl_v2.sv
// xctrl_v2: accumulator controller with async-read program ROM, a stalling data bus with
// bounded timeout, a hardware call/return stack and sticky error flags.
module xctrl_v2 #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned PROG_ADDR_W = 10,
   parameter int unsigned IMM_W       = 16,
   parameter int unsigned PROG_START  = 0,
   parameter int unsigned RB_ADDR     = 1,
   parameter int unsigned RC_ADDR     = 2,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned WAIT_MAX    = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic [PROG_ADDR_W-1:0] pc,
   input  logic [IMM_W+3:0]       instruction,
   output logic                   data_sel,
   output logic                   data_we,
   output logic [ADDR_W-1:0]      data_addr,
   output logic [DATA_W-1:0]      data_wdata,
   input  logic [DATA_W-1:0]      data_rdata,
   input  logic                   data_ready
);

   localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   localparam logic [ADDR_W-1:0]      RB_A     = ADDR_W'(RB_ADDR);
   localparam logic [ADDR_W-1:0]      RC_A     = ADDR_W'(RC_ADDR);
   localparam logic [PROG_ADDR_W-1:0] PC_RESET = PROG_ADDR_W'(PROG_START);
   localparam logic [SP_W-1:0]        SP_FULL  = SP_W'(STACK_DEPTH);
   localparam logic [CNT_W-1:0]       CNT_MAX  = CNT_W'(WAIT_MAX);

   typedef enum logic [3:0] {
      OpAddi  = 4'h0, OpAdd  = 4'h1, OpSub   = 4'h2, OpShft  = 4'h3,
      OpAnd   = 4'h4, OpXor  = 4'h5, OpLdi   = 4'h6, OpLdih  = 4'h7,
      OpRdw   = 4'h8, OpWrw  = 4'h9, OpRdwb  = 4'hA, OpWrwb  = 4'hB,
      OpBeqi  = 4'hC, OpBneqi = 4'hD, OpCall = 4'hE, OpRet   = 4'hF
   } opcode_e;

   typedef enum logic {StExec, StWait} state_e;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [PROG_ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0]      ra_q, rb_q;
   logic                   neg_q, ovf_q, tmo_q, sterr_q, carry_q;
   logic [SP_W-1:0]        sp_q;
   logic [PROG_ADDR_W-1:0] stack_q [STACK_DEPTH];

   opcode_e                op;
   logic [DATA_W-1:0]      imm, rc_val, mem_val, addend;
   logic                   mem_op, mem_wr, based;
   logic [ADDR_W-1:0]      eff_addr;
   logic                   is_rb, is_rc, ext, retire, abort;
   logic [DATA_W:0]        sum, diff;
   logic                   ovf_add, ovf_sub;
   logic [PROG_ADDR_W-1:0] pc_inc;
   logic [IDX_W-1:0]       push_idx, pop_idx;

   assign op  = opcode_e'(instruction[IMM_W+3:IMM_W]);
   assign imm = {{(DATA_W-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]};

   always_comb begin
      mem_op = 1'b0;
      mem_wr = 1'b0;
      based  = 1'b0;
      unique case (op)
         OpAdd, OpSub, OpAnd, OpXor, OpRdw: mem_op = 1'b1;
         OpWrw:  begin mem_op = 1'b1; mem_wr = 1'b1; end
         OpRdwb: begin mem_op = 1'b1; based = 1'b1; end
         OpWrwb: begin mem_op = 1'b1; mem_wr = 1'b1; based = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      rc_val           = '0;
      rc_val[DATA_W-1] = neg_q;
      rc_val[DATA_W-2] = ovf_q;
      rc_val[2]        = tmo_q;
      rc_val[1]        = sterr_q;
      rc_val[0]        = carry_q;
   end

   assign eff_addr = based ? (rb_q[ADDR_W-1:0] + instruction[ADDR_W-1:0])
                           : instruction[ADDR_W-1:0];
   assign is_rb    = (eff_addr == RB_A);
   assign is_rc    = (eff_addr == RC_A);
   assign ext      = mem_op & ~is_rb & ~is_rc;
   assign mem_val  = is_rb ? rb_q : (is_rc ? rc_val : data_rdata);

   // Bus strobes follow the ROM combinationally; the held pc keeps them stable while stalled.
   assign data_sel   = rst & ext;
   assign data_we    = rst & ext & mem_wr;
   assign data_addr  = eff_addr;
   assign data_wdata = ra_q;
   assign pc         = pc_q;

   assign retire = (state_q == StExec) ? (~ext | data_ready) : data_ready;
   assign abort  = (WAIT_MAX != 0) && (state_q == StWait) && !data_ready && (cnt_q == CNT_MAX);

   assign addend  = (op == OpAddi) ? imm : mem_val;
   assign sum     = {1'b0, ra_q} + {1'b0, addend};
   assign diff    = {1'b0, ra_q} - {1'b0, mem_val};
   assign ovf_add = (ra_q[DATA_W-1] == addend[DATA_W-1]) & (sum[DATA_W-1] != ra_q[DATA_W-1]);
   assign ovf_sub = (ra_q[DATA_W-1] != mem_val[DATA_W-1]) & (diff[DATA_W-1] != ra_q[DATA_W-1]);

   assign pc_inc   = pc_q + PROG_ADDR_W'(1);
   assign push_idx = IDX_W'(sp_q);
   assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StExec;
         cnt_q   <= '0;
         pc_q    <= PC_RESET;
         ra_q    <= '0;
         rb_q    <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
         sterr_q <= 1'b0;
         carry_q <= 1'b0;
         sp_q    <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
      end else if (retire) begin
         state_q <= StExec;
         cnt_q   <= '0;
         pc_q    <= pc_inc;
         unique case (op)
            OpAddi, OpAdd: begin
               ra_q    <= sum[DATA_W-1:0];
               carry_q <= sum[DATA_W];
               neg_q   <= sum[DATA_W-1];
               ovf_q   <= ovf_add;
            end
            OpSub: begin
               ra_q    <= diff[DATA_W-1:0];
               carry_q <= diff[DATA_W];
               neg_q   <= diff[DATA_W-1];
               ovf_q   <= ovf_sub;
            end
            OpShft: begin
               if (instruction[IMM_W-1]) begin
                  ra_q    <= {ra_q[DATA_W-2:0], 1'b0};
                  carry_q <= ra_q[DATA_W-1];
               end else begin
                  ra_q    <= {1'b0, ra_q[DATA_W-1:1]};
                  carry_q <= ra_q[0];
               end
            end
            OpAnd:  ra_q <= ra_q & mem_val;
            OpXor:  ra_q <= ra_q ^ mem_val;
            OpLdi:  ra_q <= imm;
            OpLdih: ra_q[DATA_W-1:IMM_W] <= imm[DATA_W-IMM_W-1:0];
            OpRdw, OpRdwb: ra_q <= mem_val;
            OpWrw, OpWrwb: begin
               if (is_rb) begin
                  rb_q <= ra_q;
               end else if (is_rc) begin
                  neg_q   <= ra_q[DATA_W-1];
                  ovf_q   <= ra_q[DATA_W-2];
                  tmo_q   <= ra_q[2];
                  sterr_q <= ra_q[1];
                  carry_q <= ra_q[0];
               end
            end
            OpBeqi, OpBneqi: begin
               if ((ra_q == '0) == (op == OpBeqi)) pc_q <= instruction[PROG_ADDR_W-1:0];
               ra_q <= ra_q - DATA_W'(1);
            end
            OpCall: begin
               pc_q <= instruction[PROG_ADDR_W-1:0];
               if (sp_q != SP_FULL) begin
                  stack_q[push_idx] <= pc_inc;
                  sp_q              <= sp_q + SP_W'(1);
               end else begin
                  sterr_q <= 1'b1;
               end
            end
            OpRet: begin
               if (sp_q != '0) begin
                  pc_q <= stack_q[pop_idx];
                  sp_q <= sp_q - SP_W'(1);
               end else begin
                  sterr_q <= 1'b1;
               end
            end
         endcase
      end else if (abort) begin
         // Timed-out access: drop the write / keep RA and move on.
         state_q <= StExec;
         cnt_q   <= '0;
         pc_q    <= pc_inc;
         tmo_q   <= 1'b1;
      end else if (state_q == StExec) begin
         state_q <= StWait;
         cnt_q   <= CNT_W'(1);
      end else if (cnt_q != '1) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_xctrl_v2.sv
// Directed bench for xctrl_v2: arithmetic/flags, bus stalls and timeout, call stack,
// pointer-based addressing and branch loops, with hand-computed expectations.
module tb_xctrl_v2;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  pc;
   logic [19:0] instruction;
   logic        data_sel, data_we;
   logic [9:0]  data_addr;
   logic [31:0] data_wdata, data_rdata;
   logic        data_ready;

   logic [19:0] rom [0:1023];
   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;
   assign instruction = rom[pc];

   xctrl_v2 dut (
      .clk         (clk),
      .rst         (rst),
      .pc          (pc),
      .instruction (instruction),
      .data_sel    (data_sel),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_rdata  (data_rdata),
      .data_ready  (data_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [19:0] ins(input logic [3:0] op, input logic [15:0] imm);
      return {op, imm};
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic enter_reset();
      @(negedge clk);
      rst        = 1'b0;
      data_ready = 1'b1;
      data_rdata = '0;
      for (int i = 0; i < 1024; i++) rom[i] = ins(4'h6, 16'h0000);
   endtask

   task automatic leave_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   int n;
   int exp_pc [15] = '{'h20, 'h30, 'h40, 'h50, 'h60, 'h61, 'h41, 'h42, 'h43, 'h44,
                       'h31, 'h21, 'h01, 'h02, 'h03};

   initial begin
      rst        = 1'b0;
      data_ready = 1'b1;
      data_rdata = '0;

      // Reset state, then LDI 5; ADDI -6; RDW RC
      enter_reset();
      rom[0] = ins(4'h6, 16'h0005);
      rom[1] = ins(4'h0, 16'hFFFA);
      rom[2] = ins(4'h8, 16'h0002);
      #1;
      check("rst_pc", 32'(pc), 32'h0);
      check("rst_sel", 32'(data_sel), 32'h0);
      check("rst_ra", data_wdata, 32'h0);
      leave_reset();
      tick();
      check("ldi_ra", data_wdata, 32'h5);
      tick();
      check("addi_pc", 32'(pc), 32'h2);
      check("addi_ra", data_wdata, 32'hFFFF_FFFF);
      check("rc_internal_sel", 32'(data_sel), 32'h0);
      tick();
      check("addi_flags", data_wdata, 32'h8000_0000);

      // Overflowing ADD, borrowing SUB, shifts, logic ops
      enter_reset();
      rom[0]  = ins(4'h6, 16'hFFFF);
      rom[1]  = ins(4'h7, 16'h7FFF);
      rom[2]  = ins(4'h1, 16'h0010);
      rom[3]  = ins(4'h8, 16'h0002);
      rom[4]  = ins(4'h2, 16'h0010);
      rom[5]  = ins(4'h8, 16'h0002);
      rom[6]  = ins(4'h3, 16'hFFFF);
      rom[7]  = ins(4'h3, 16'h0001);
      rom[8]  = ins(4'h5, 16'h0010);
      rom[9]  = ins(4'h4, 16'h0010);
      rom[10] = ins(4'h8, 16'h0002);
      leave_reset();
      tick();
      tick();
      check("ldih_ra", data_wdata, 32'h7FFF_FFFF);
      check("add_sel", 32'(data_sel), 32'h1);
      check("add_addr", 32'(data_addr), 32'h10);
      check("add_we", 32'(data_we), 32'h0);
      data_rdata = 32'h1;
      tick();
      check("add_pc", 32'(pc), 32'h3);
      check("add_ra", data_wdata, 32'h8000_0000);
      tick();
      check("add_flags", data_wdata, 32'hC000_0000);
      data_rdata = 32'hC000_0001;
      tick();
      check("sub_ra", data_wdata, 32'hFFFF_FFFF);
      tick();
      check("sub_flags", data_wdata, 32'h8000_0001);
      tick();
      check("shl_ra", data_wdata, 32'h0000_0002);
      tick();
      check("shr_ra", data_wdata, 32'h0000_0001);
      data_rdata = 32'hF;
      tick();
      check("xor_ra", data_wdata, 32'hE);
      data_rdata = 32'h6;
      tick();
      check("and_ra", data_wdata, 32'h6);
      tick();
      check("logic_flags", data_wdata, 32'h8000_0000);

      // Stalled read, timeout, flag clear, reset mid-stall
      enter_reset();
      rom[0] = ins(4'h6, 16'h0055);
      rom[1] = ins(4'h8, 16'h0010);
      rom[2] = ins(4'h8, 16'h0020);
      rom[3] = ins(4'h8, 16'h0002);
      rom[4] = ins(4'h6, 16'h0000);
      rom[5] = ins(4'h9, 16'h0002);
      rom[6] = ins(4'h8, 16'h0002);
      rom[7] = ins(4'h8, 16'h0010);
      leave_reset();
      tick();
      data_ready = 1'b0;
      data_rdata = 32'hDEAD_0000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_pc", 32'(pc), 32'h1);
         check("stall_sel", 32'(data_sel), 32'h1);
         check("stall_ra", data_wdata, 32'h55);
      end
      data_ready = 1'b1;
      data_rdata = 32'h1234_5678;
      tick();
      check("stall_done_pc", 32'(pc), 32'h2);
      check("stall_done_ra", data_wdata, 32'h1234_5678);
      data_ready = 1'b0;
      n = 0;
      while (pc == 10'd2 && n < 40) begin
         tick();
         n++;
      end
      check("tmo_cycles", 32'(n), 32'd16);
      check("tmo_pc", 32'(pc), 32'h3);
      check("tmo_ra", data_wdata, 32'h1234_5678);
      data_ready = 1'b1;
      tick();
      check("tmo_flag", data_wdata, 32'h4);
      tick();
      tick();
      tick();
      check("tmo_cleared", data_wdata, 32'h0);
      data_ready = 1'b0;
      tick();
      tick();
      check("pre_rst_pc", 32'(pc), 32'h7);
      rst = 1'b0;
      #1;
      check("midstall_rst_pc", 32'(pc), 32'h0);
      check("midstall_rst_sel", 32'(data_sel), 32'h0);

      // Call stack: four pushes, overflow, LIFO returns, underflow
      enter_reset();
      rom['h00] = ins(4'hE, 16'h0020);
      rom['h20] = ins(4'hE, 16'h0030);
      rom['h30] = ins(4'hE, 16'h0040);
      rom['h40] = ins(4'hE, 16'h0050);
      rom['h50] = ins(4'hE, 16'h0060);
      rom['h60] = ins(4'h8, 16'h0002);
      rom['h61] = ins(4'hF, 16'h0000);
      rom['h41] = ins(4'h6, 16'h0000);
      rom['h42] = ins(4'h9, 16'h0002);
      rom['h43] = ins(4'h8, 16'h0002);
      rom['h44] = ins(4'hF, 16'h0000);
      rom['h31] = ins(4'hF, 16'h0000);
      rom['h21] = ins(4'hF, 16'h0000);
      rom['h01] = ins(4'hF, 16'h0000);
      rom['h02] = ins(4'h8, 16'h0002);
      leave_reset();
      for (int i = 0; i < 15; i++) begin
         tick();
         check($sformatf("stack_pc_%0d", i), 32'(pc), 32'(exp_pc[i]));
         if (i == 5)  check("call_full_sterr", data_wdata, 32'h2);
         if (i == 9)  check("sterr_cleared", data_wdata, 32'h0);
         if (i == 14) check("ret_empty_sterr", data_wdata, 32'h2);
      end

      // RB pointer addressing with wrap
      enter_reset();
      rom[0] = ins(4'h6, 16'h0100);
      rom[1] = ins(4'h9, 16'h0001);
      rom[2] = ins(4'hA, 16'h0003);
      rom[3] = ins(4'hB, 16'hFFFF);
      rom[4] = ins(4'h8, 16'h0001);
      leave_reset();
      tick();
      check("wrw_rb_sel", 32'(data_sel), 32'h0);
      tick();
      check("rdwb_sel", 32'(data_sel), 32'h1);
      check("rdwb_addr", 32'(data_addr), 32'h103);
      check("rdwb_we", 32'(data_we), 32'h0);
      data_rdata = 32'h0000_CAFE;
      tick();
      check("rdwb_ra", data_wdata, 32'h0000_CAFE);
      check("wrwb_addr", 32'(data_addr), 32'h0FF);
      check("wrwb_we", 32'(data_we), 32'h1);
      tick();
      tick();
      check("rdw_rb", data_wdata, 32'h100);

      // BNEQI countdown loop, then BEQI taken
      enter_reset();
      rom[0] = ins(4'h6, 16'h0002);
      rom[1] = ins(4'hD, 16'h0001);
      rom[2] = ins(4'h8, 16'h0002);
      rom[3] = ins(4'hC, 16'h0010);
      leave_reset();
      tick();
      tick();
      check("bneq1_pc", 32'(pc), 32'h1);
      check("bneq1_ra", data_wdata, 32'h1);
      tick();
      check("bneq2_pc", 32'(pc), 32'h1);
      check("bneq2_ra", data_wdata, 32'h0);
      tick();
      check("bneq_fall_pc", 32'(pc), 32'h2);
      check("bneq_fall_ra", data_wdata, 32'hFFFF_FFFF);
      tick();
      check("branch_flags", data_wdata, 32'h0);
      tick();
      check("beqi_pc", 32'(pc), 32'h10);
      check("beqi_ra", data_wdata, 32'hFFFF_FFFF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
